slink_app_rx_checker: RTL and testbench

Synthesizable, parametrised checker for the S-Link RX application interface, usable in simulation and in FPGA/emulation builds.
- Parses short and long packets across a configurable data width.
- Compares every received byte against an expected-byte FIFO filled by a generator or driver.
- Detects protocol violations, CRC-corruption placement errors and underflow.
- Exposes registered error pulses, sticky status and counters; sits beside the RX application interface in bench or on-chip test top.

---
 rtl/slink_app_rx_checker.sv | 255 +++++++++++++++++++++++++
 tb/tb_slink_app_rx_checker.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/slink_app_rx_checker.sv
// slink_app_rx_checker
//   Checks the S-Link RX application interface against a FIFO of expected
//   bytes. Short and long packets are parsed at APP_DATA_WIDTH/8 lanes per
//   cycle. Every packet byte is compared in this order: data_id,
//   word_count[7:0], word_count[15:8], then payload lanes 0..NB-1.
//   Error pulses, sticky status and counters are registered outputs.
//
// Ports
//   link_clk, link_reset        clock, asynchronous active-high reset
//   enable                      0 = ignore RX inputs (FIFO pushes still taken)
//   rx_sop/rx_valid/rx_data_id/rx_word_count/rx_app_data/rx_crc_corrupted
//                               RX application interface being observed
//   exp_valid/exp_byte          expected-byte push
//   exp_ready/exp_level         FIFO not full / occupancy
//   in_pkt                      long packet in progress
//   err_mismatch/err_underflow/err_protocol/err_crc/err_timeout
//                               one-cycle error pulses
//   err_sticky, pkt_cnt, err_cnt  status and counters
//
// Build option
//   SLINK_APP_RX_CHECKER_TIMEOUT_EN : enables the long-packet stall timeout.
//   Without it, err_timeout is tied low.
module slink_app_rx_checker #(
  parameter int unsigned APP_DATA_WIDTH   = 32,
  parameter int unsigned EXP_DEPTH        = 64,
  parameter logic [7:0]  SHORT_PKT_MAX_ID = 8'h2F,
  parameter int unsigned TIMEOUT_CYCLES   = 1024
) (
  input  logic                         link_clk,
  input  logic                         link_reset,
  input  logic                         enable,
  input  logic                         rx_sop,
  input  logic [7:0]                   rx_data_id,
  input  logic [15:0]                  rx_word_count,
  input  logic [APP_DATA_WIDTH-1:0]    rx_app_data,
  input  logic                         rx_valid,
  input  logic                         rx_crc_corrupted,
  input  logic                         exp_valid,
  input  logic [7:0]                   exp_byte,
  output logic                         exp_ready,
  output logic [$clog2(EXP_DEPTH):0]   exp_level,
  output logic                         in_pkt,
  output logic                         err_mismatch,
  output logic                         err_underflow,
  output logic                         err_protocol,
  output logic                         err_crc,
  output logic                         err_timeout,
  output logic                         err_sticky,
  output logic [31:0]                  pkt_cnt,
  output logic [15:0]                  err_cnt
);

  localparam int unsigned NB = APP_DATA_WIDTH / 8;
  localparam int unsigned NC = NB + 3;
  localparam int unsigned AW = $clog2(EXP_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [15:0] NB16 = 16'(NB);

  typedef enum logic {S_IDLE, S_LONG} state_t;

  state_t            state_q, state_d;
  logic [15:0]       rem_q, rem_d;
  logic [7:0]        mem_q [EXP_DEPTH];
  logic [AW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [LW-1:0]     level_q, level_d;
  logic              push;

  logic [7:0]        cmp_byte [NC];
  logic [LW-1:0]     n_req, n_pop;
  logic [15:0]       lanes;
  logic              hdr;
  logic              e_mism, e_under, e_proto, e_crc, pkt_done, long_done, err_any;

  logic              err_mismatch_q, err_underflow_q, err_protocol_q, err_crc_q;
  logic              err_sticky_q;
  logic [31:0]       pkt_cnt_q;
  logic [15:0]       err_cnt_q;

`ifdef SLINK_APP_RX_CHECKER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]     to_q, to_d;
  logic              e_to;
  logic              err_timeout_q;
`endif

  assign exp_ready = (level_q != LW'(EXP_DEPTH));
  assign push      = exp_valid && exp_ready;

  // Packet parsing: decides how many bytes this cycle must be checked and
  // what they are; the FIFO side below decides how many are actually present.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    hdr       = 1'b0;
    lanes     = '0;
    e_proto   = 1'b0;
    e_crc     = 1'b0;
    pkt_done  = 1'b0;
    long_done = 1'b0;
    for (int unsigned i = 0; i < NC; i++) cmp_byte[i] = '0;
`ifdef SLINK_APP_RX_CHECKER_TIMEOUT_EN
    to_d = '0;
    e_to = 1'b0;
`endif

    if (enable) begin
      if (rx_sop && rx_valid) begin
        // A new SOP inside a long packet abandons it; its remaining
        // expected bytes stay in the FIFO.
        if (state_q == S_LONG) e_proto = 1'b1;
        hdr = 1'b1;
        if (rx_data_id <= SHORT_PKT_MAX_ID) begin
          pkt_done = 1'b1;
          state_d  = S_IDLE;
        end else begin
          lanes = (rx_word_count > NB16) ? NB16 : rx_word_count;
          if (rx_word_count == lanes) begin
            pkt_done  = 1'b1;
            long_done = 1'b1;
            state_d   = S_IDLE;
            rem_d     = '0;
          end else begin
            state_d = S_LONG;
            rem_d   = rx_word_count - lanes;
          end
        end
      end else if (rx_valid) begin
        if (state_q == S_IDLE) begin
          e_proto = 1'b1;
        end else begin
          lanes = (rem_q > NB16) ? NB16 : rem_q;
          rem_d = rem_q - lanes;
          if (rem_q == lanes) begin
            pkt_done  = 1'b1;
            long_done = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end else if (rx_sop) begin
        e_proto = 1'b1;
      end

      if (rx_valid && rx_crc_corrupted) begin
        e_crc = 1'b1;
        if (!long_done) e_proto = 1'b1;
      end

`ifdef SLINK_APP_RX_CHECKER_TIMEOUT_EN
      if (state_q == S_LONG && !rx_valid) begin
        if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
          e_to    = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
`endif
    end
`ifdef SLINK_APP_RX_CHECKER_TIMEOUT_EN
    else if (state_q == S_LONG) begin
      to_d = to_q;
    end
`endif

    // Payload lanes follow the three header bytes on an SOP cycle.
    for (int unsigned i = 0; i < NB; i++) begin
      if (hdr) cmp_byte[i+3] = rx_app_data[8*i +: 8];
      else     cmp_byte[i]   = rx_app_data[8*i +: 8];
    end
    if (hdr) begin
      cmp_byte[0] = rx_data_id;
      cmp_byte[1] = rx_word_count[7:0];
      cmp_byte[2] = rx_word_count[15:8];
    end
  end

  assign n_req = LW'(lanes) + (hdr ? LW'(3) : '0);

  // Only bytes already stored are compared; a shortfall pops what exists.
  always_comb begin
    e_under = (n_req > level_q);
    n_pop   = e_under ? level_q : n_req;
    e_mism  = 1'b0;
    for (int unsigned i = 0; i < NC; i++) begin
      if (LW'(i) < n_pop && mem_q[rd_ptr_q + AW'(i)] != cmp_byte[i]) e_mism = 1'b1;
    end
    level_d = level_q + LW'(push) - n_pop;
  end

`ifdef SLINK_APP_RX_CHECKER_TIMEOUT_EN
  assign err_any = e_mism | e_under | e_proto | e_crc | e_to;
`else
  assign err_any = e_mism | e_under | e_proto | e_crc;
`endif

  always_ff @(posedge link_clk) begin
    if (push) mem_q[wr_ptr_q] <= exp_byte;
  end

  always_ff @(posedge link_clk or posedge link_reset) begin
    if (link_reset) begin
      state_q         <= S_IDLE;
      rem_q           <= '0;
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      level_q         <= '0;
      err_mismatch_q  <= 1'b0;
      err_underflow_q <= 1'b0;
      err_protocol_q  <= 1'b0;
      err_crc_q       <= 1'b0;
      err_sticky_q    <= 1'b0;
      pkt_cnt_q       <= '0;
      err_cnt_q       <= '0;
    end else begin
      state_q         <= state_d;
      rem_q           <= rem_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      rd_ptr_q        <= rd_ptr_q + AW'(n_pop);
      level_q         <= level_d;
      err_mismatch_q  <= e_mism;
      err_underflow_q <= e_under;
      err_protocol_q  <= e_proto;
      err_crc_q       <= e_crc;
      err_sticky_q    <= err_sticky_q | err_any;
      if (pkt_done) pkt_cnt_q <= pkt_cnt_q + 32'd1;
      if (err_any && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

`ifdef SLINK_APP_RX_CHECKER_TIMEOUT_EN
  always_ff @(posedge link_clk or posedge link_reset) begin
    if (link_reset) begin
      to_q          <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      to_q          <= to_d;
      err_timeout_q <= e_to;
    end
  end
  assign err_timeout = err_timeout_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign exp_level     = level_q;
  assign in_pkt        = (state_q == S_LONG);
  assign err_mismatch  = err_mismatch_q;
  assign err_underflow = err_underflow_q;
  assign err_protocol  = err_protocol_q;
  assign err_crc       = err_crc_q;
  assign err_sticky    = err_sticky_q;
  assign pkt_cnt       = pkt_cnt_q;
  assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_slink_app_rx_checker.sv
// tb_slink_app_rx_checker
//   Directed bench for slink_app_rx_checker at APP_DATA_WIDTH=32 (4 lanes),
//   EXP_DEPTH=64, TIMEOUT_CYCLES=16. A table of RX cycles with hand-computed
//   expected status is applied in sequence, followed by sequences for a full
//   FIFO drained by a long packet, the long-packet stall and reset mid-packet.
module tb_slink_app_rx_checker;

  logic        link_clk = 1'b0;
  logic        link_reset;
  logic        enable;
  logic        rx_sop;
  logic [7:0]  rx_data_id;
  logic [15:0] rx_word_count;
  logic [31:0] rx_app_data;
  logic        rx_valid;
  logic        rx_crc_corrupted;
  logic        exp_valid;
  logic [7:0]  exp_byte;
  logic        exp_ready;
  logic [6:0]  exp_level;
  logic        in_pkt;
  logic        err_mismatch, err_underflow, err_protocol, err_crc, err_timeout;
  logic        err_sticky;
  logic [31:0] pkt_cnt;
  logic [15:0] err_cnt;

  int n_vec  = 0;
  int n_miss = 0;
  int n_chk  = 0;

  always #5 link_clk = ~link_clk;

  slink_app_rx_checker #(
    .APP_DATA_WIDTH  (32),
    .EXP_DEPTH       (64),
    .SHORT_PKT_MAX_ID(8'h2F),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .link_clk        (link_clk),
    .link_reset      (link_reset),
    .enable          (enable),
    .rx_sop          (rx_sop),
    .rx_data_id      (rx_data_id),
    .rx_word_count   (rx_word_count),
    .rx_app_data     (rx_app_data),
    .rx_valid        (rx_valid),
    .rx_crc_corrupted(rx_crc_corrupted),
    .exp_valid       (exp_valid),
    .exp_byte        (exp_byte),
    .exp_ready       (exp_ready),
    .exp_level       (exp_level),
    .in_pkt          (in_pkt),
    .err_mismatch    (err_mismatch),
    .err_underflow   (err_underflow),
    .err_protocol    (err_protocol),
    .err_crc         (err_crc),
    .err_timeout     (err_timeout),
    .err_sticky      (err_sticky),
    .pkt_cnt         (pkt_cnt),
    .err_cnt         (err_cnt)
  );

  // pre: bytes pushed before the RX cycle, read left to right, right-aligned.
  typedef struct packed {
    logic        en, sop, valid, crc;
    logic [7:0]  id;
    logic [15:0] wc;
    logic [31:0] data;
    logic        pv;
    logic [7:0]  pb;
    int          npre;
    logic [71:0] pre;
    logic        e_inp, e_mism, e_under, e_proto, e_crc, e_sticky;
    int          e_level, e_pkt, e_errcnt;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  function automatic vec_t mkv(
    input logic en, sop, valid, crc, input logic [7:0] id, input logic [15:0] wc,
    input logic [31:0] data, input logic pv, input logic [7:0] pb,
    input int npre, input logic [71:0] pre,
    input logic inp, mism, under, proto, crce, sticky,
    input int level, pkt, errcnt);
    vec_t v;
    v.en = en; v.sop = sop; v.valid = valid; v.crc = crc; v.id = id; v.wc = wc;
    v.data = data; v.pv = pv; v.pb = pb; v.npre = npre; v.pre = pre;
    v.e_inp = inp; v.e_mism = mism; v.e_under = under; v.e_proto = proto;
    v.e_crc = crce; v.e_sticky = sticky;
    v.e_level = level; v.e_pkt = pkt; v.e_errcnt = errcnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic rx_idle();
    enable = 1'b1; rx_sop = 1'b0; rx_valid = 1'b0; rx_crc_corrupted = 1'b0;
    rx_data_id = '0; rx_word_count = '0; rx_app_data = '0; exp_valid = 1'b0; exp_byte = '0;
  endtask

  task automatic push1(input logic [7:0] b);
    exp_valid = 1'b1; exp_byte = b;
    @(negedge link_clk);
    exp_valid = 1'b0;
  endtask

  task automatic rx_cycle(input logic sop, input logic [7:0] id, input logic [15:0] wc,
                          input logic [31:0] data);
    rx_sop = sop; rx_valid = 1'b1; rx_data_id = id; rx_word_count = wc; rx_app_data = data;
    @(negedge link_clk);
    rx_idle();
  endtask

  task automatic apply(input vec_t v, input int idx);
    string p;
    p = $sformatf("v%0d", idx);
    for (int k = 0; k < v.npre; k++) push1(v.pre[8*(v.npre-1-k) +: 8]);
    enable = v.en; rx_sop = v.sop; rx_valid = v.valid; rx_crc_corrupted = v.crc;
    rx_data_id = v.id; rx_word_count = v.wc; rx_app_data = v.data;
    exp_valid = v.pv; exp_byte = v.pb;
    @(negedge link_clk);
    rx_idle();
    n_vec++;
    chk({p, ".in_pkt"},        32'(in_pkt),        32'(v.e_inp));
    chk({p, ".err_mismatch"},  32'(err_mismatch),  32'(v.e_mism));
    chk({p, ".err_underflow"}, 32'(err_underflow), 32'(v.e_under));
    chk({p, ".err_protocol"},  32'(err_protocol),  32'(v.e_proto));
    chk({p, ".err_crc"},       32'(err_crc),       32'(v.e_crc));
    chk({p, ".err_timeout"},   32'(err_timeout),   32'd0);
    chk({p, ".err_sticky"},    32'(err_sticky),    32'(v.e_sticky));
    chk({p, ".exp_level"},     32'(exp_level),     32'(v.e_level));
    chk({p, ".pkt_cnt"},       pkt_cnt,            32'(v.e_pkt));
    chk({p, ".err_cnt"},       32'(err_cnt),       32'(v.e_errcnt));
  endtask

  task automatic chk_reset_state(input string p);
    n_vec++;
    chk({p, ".in_pkt"},    32'(in_pkt),    32'd0);
    chk({p, ".exp_ready"}, 32'(exp_ready), 32'd1);
    chk({p, ".exp_level"}, 32'(exp_level), 32'd0);
    chk({p, ".errs"}, 32'({err_mismatch, err_underflow, err_protocol, err_crc, err_timeout}), 32'd0);
    chk({p, ".err_sticky"}, 32'(err_sticky), 32'd0);
    chk({p, ".pkt_cnt"},    pkt_cnt,         32'd0);
    chk({p, ".err_cnt"},    32'(err_cnt),    32'd0);
  endtask

  initial begin
    //            en sop val crc id     wc        data          pv pb    npre pre
    //            inp mism und pro crc stk  level pkt errcnt
    vecs[0]  = mkv(1,1,1,0, 8'h10, 16'h1234, 32'h0,        0,8'h00, 3, 72'h103412,
                   0,0,0,0,0,0, 0,1,0);
    vecs[1]  = mkv(1,1,1,0, 8'h40, 16'h0006, 32'hA3A2A1A0, 0,8'h00, 9, 72'h400600A0A1A2A3A4A5,
                   1,0,0,0,0,0, 2,1,0);
    vecs[2]  = mkv(1,0,1,0, 8'h00, 16'h0000, 32'hFFFFA5A4, 0,8'h00, 0, 72'h0,
                   0,0,0,0,0,0, 0,2,0);
    vecs[3]  = mkv(1,1,1,0, 8'h40, 16'h0006, 32'hB300B1B0, 0,8'h00, 9, 72'h400600B0B1B2B3B4B5,
                   1,1,0,0,0,1, 2,2,1);
    vecs[4]  = mkv(1,0,1,0, 8'h00, 16'h0000, 32'h0000B5B4, 0,8'h00, 0, 72'h0,
                   0,0,0,0,0,1, 0,3,1);
    vecs[5]  = mkv(1,1,1,0, 8'h41, 16'h0008, 32'hC3C2C1C0, 0,8'h00, 7, 72'h410800C0C1C2C3,
                   1,0,0,0,0,1, 0,3,1);
    vecs[6]  = mkv(1,1,1,0, 8'h42, 16'h0005, 32'hD3D2D1D0, 0,8'h00, 8, 72'h420500D0D1D2D3D4,
                   1,0,0,1,0,1, 1,3,2);
    vecs[7]  = mkv(1,0,1,1, 8'h00, 16'h0000, 32'h000000D4, 0,8'h00, 0, 72'h0,
                   0,0,0,0,1,1, 0,4,3);
    vecs[8]  = mkv(1,1,1,0, 8'h05, 16'h0000, 32'h0,        0,8'h00, 0, 72'h0,
                   0,0,1,0,0,1, 0,5,4);
    vecs[9]  = mkv(1,0,1,0, 8'h00, 16'h0000, 32'h12345678, 0,8'h00, 1, 72'h20,
                   0,0,0,1,0,1, 1,5,5);
    vecs[10] = mkv(1,1,0,0, 8'h20, 16'h0000, 32'h0,        0,8'h00, 0, 72'h0,
                   0,0,0,1,0,1, 1,5,6);
    vecs[11] = mkv(0,1,1,1, 8'h20, 16'h0000, 32'h0,        1,8'h00, 0, 72'h0,
                   0,0,0,0,0,1, 2,5,6);
    vecs[12] = mkv(1,1,1,1, 8'h20, 16'h0000, 32'h0,        0,8'h00, 1, 72'h00,
                   0,0,0,1,1,1, 0,6,7);
    vecs[13] = mkv(1,1,1,1, 8'h50, 16'h0000, 32'h0,        0,8'h00, 3, 72'h500000,
                   0,0,0,0,1,1, 0,7,8);
    vecs[14] = mkv(1,1,1,0, 8'h51, 16'h0003, 32'hFFE2E1E0, 0,8'h00, 6, 72'h510300E0E1E2,
                   0,0,0,0,0,1, 0,8,8);
    vecs[15] = mkv(1,1,1,1, 8'h52, 16'h0008, 32'hF3F2F1F0, 0,8'h00, 7, 72'h520800F0F1F2F3,
                   1,0,0,1,1,1, 0,8,9);
    vecs[16] = mkv(1,0,1,0, 8'h00, 16'h0000, 32'hF7F6F5F4, 0,8'h00, 4, 72'hF4F5F6F7,
                   0,0,0,0,0,1, 0,9,9);

    rx_idle();
    link_reset = 1'b1;
    repeat (3) @(negedge link_clk);
    chk_reset_state("reset");
    link_reset = 1'b0;
    @(negedge link_clk);
    chk_reset_state("post_reset");

    for (int i = 0; i < NV; i++) apply(vecs[i], i);

    // Fill the FIFO completely, try one extra push, then drain it with a
    // 61-byte long packet (3 header + 61 payload = 64 bytes).
    push1(8'h60); push1(8'h3D); push1(8'h00);
    for (int k = 0; k < 61; k++) push1(8'(k));
    n_vec++;
    chk("full.exp_level", 32'(exp_level), 32'd64);
    chk("full.exp_ready", 32'(exp_ready), 32'd0);
    push1(8'hEE);
    n_vec++;
    chk("full.refused_level", 32'(exp_level), 32'd64);
    rx_cycle(1'b1, 8'h60, 16'd61, {8'd3, 8'd2, 8'd1, 8'd0});
    n_vec++;
    chk("drain.sop_level", 32'(exp_level), 32'd57);
    chk("drain.sop_ready", 32'(exp_ready), 32'd1);
    chk("drain.sop_in_pkt", 32'(in_pkt), 32'd1);
    chk("drain.sop_mism", 32'(err_mismatch), 32'd0);
    for (int c = 1; c < 15; c++) begin
      rx_cycle(1'b0, 8'h00, 16'h0, {8'(4*c+3), 8'(4*c+2), 8'(4*c+1), 8'(4*c)});
      n_vec++;
      chk($sformatf("drain.c%0d.errs", c), 32'({err_mismatch, err_underflow, err_protocol}), 32'd0);
      chk($sformatf("drain.c%0d.level", c), 32'(exp_level), 32'(57 - 4*c));
    end
    rx_cycle(1'b0, 8'h00, 16'h0, {24'hFFFFFF, 8'd60});
    n_vec++;
    chk("drain.end_level",  32'(exp_level), 32'd0);
    chk("drain.end_in_pkt", 32'(in_pkt),    32'd0);
    chk("drain.end_mism",   32'(err_mismatch), 32'd0);
    chk("drain.end_pkt",    pkt_cnt,        32'd10);
    chk("drain.end_errcnt", 32'(err_cnt),   32'd9);

    // Long packet that stalls after its SOP cycle (rem = 4).
    push1(8'h61); push1(8'h08); push1(8'h00);
    push1(8'h01); push1(8'h02); push1(8'h03); push1(8'h04);
    rx_cycle(1'b1, 8'h61, 16'd8, 32'h04030201);
    n_vec++;
    chk("stall.in_pkt", 32'(in_pkt), 32'd1);
    chk("stall.level",  32'(exp_level), 32'd0);
    repeat (15) @(negedge link_clk);
    n_vec++;
    chk("stall15.err_timeout", 32'(err_timeout), 32'd0);
    chk("stall15.in_pkt",      32'(in_pkt),      32'd1);
    @(negedge link_clk);
    n_vec++;
`ifdef SLINK_APP_RX_CHECKER_TIMEOUT_EN
    chk("stall16.err_timeout", 32'(err_timeout), 32'd1);
    chk("stall16.in_pkt",      32'(in_pkt),      32'd0);
    chk("stall16.err_cnt",     32'(err_cnt),     32'd10);
    @(negedge link_clk);
    chk("stall17.err_timeout", 32'(err_timeout), 32'd0);
`else
    chk("stall16.err_timeout", 32'(err_timeout), 32'd0);
    chk("stall16.in_pkt",      32'(in_pkt),      32'd1);
`endif

    // Reset in the middle of a long packet with bytes still queued.
    push1(8'h62); push1(8'h08); push1(8'h00);
    push1(8'h11); push1(8'h22); push1(8'h33); push1(8'h44);
    push1(8'hAA); push1(8'hBB);
    rx_cycle(1'b1, 8'h62, 16'd8, 32'h44332211);
    n_vec++;
    chk("midrst.in_pkt", 32'(in_pkt), 32'd1);
    chk("midrst.level",  32'(exp_level), 32'd2);
    #2 link_reset = 1'b1;
    #1 chk_reset_state("midrst.async");
    @(negedge link_clk);
    link_reset = 1'b0;
    @(negedge link_clk);
    chk_reset_state("midrst.after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
